// File: rtl/present_key_schedule.sv
// present_key_schedule
// Expands one PRESENT-80 cipher key into all NUM_ROUNDS+1 key-register states
// in a single clock. The update chain is fully unrolled combinational logic
// followed by one register bank. The cipher datapath takes bits [79:16] of
// each entry as its round key.
module present_key_schedule #(
    parameter int KEY_SIZE   = 80,
    parameter int NUM_ROUNDS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_SIZE-1:0] orig_key,
    output logic [KEY_SIZE-1:0] keys [0:NUM_ROUNDS]
);

    // PRESENT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One key-register update: rotate left by 61, S-box the top nibble,
    // then XOR the 5-bit round counter into bits [19:15].
    function automatic logic [79:0] key_update(input logic [79:0] k,
                                               input logic [4:0]  rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    logic [KEY_SIZE-1:0] state [0:NUM_ROUNDS];

    // Unrolled update chain; the round counter is the low five bits of the
    // index, so the last step (index 32) XORs zero.
    always_comb begin
        logic [KEY_SIZE-1:0] k;
        k        = orig_key;
        state[0] = k;
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
            k        = key_update(k, 5'(i));
            state[i] = k;
        end
    end

    // Output bank: cleared by synchronous active-low reset, otherwise loads
    // the whole schedule of the current key every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                keys[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                keys[i] <= state[i];
            end
        end
    end

endmodule

// File: tb/tb_present_key_schedule.sv
// tb_present_key_schedule
// Scoreboard bench: the stimulus process pushes the expected bank for every
// edge it drives; an independent monitor pops one entry per edge and compares
// all 33 entries. The reference model works with shifts, masks and a lookup
// table on whole 80-bit values.
module tb_present_key_schedule;

    localparam int KS = 80;
    localparam int NR = 32;

    typedef logic [NR:0][KS-1:0] bank_t;

    logic          clk;
    logic          reset;
    logic [KS-1:0] orig_key;
    logic [KS-1:0] keys [0:NR];

    int checks = 0;
    int errors = 0;

    bank_t exp_q[$];

    logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_key_schedule #(.KEY_SIZE(KS), .NUM_ROUNDS(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .orig_key (orig_key),
        .keys     (keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step: circular rotate via shifts, nibble substitution by table
    // lookup, counter (round number modulo 32) XORed in at bit 15.
    function automatic logic [KS-1:0] ref_step(input logic [KS-1:0] k, input int rnd);
        logic [KS-1:0] r;
        logic [KS-1:0] top_mask;
        logic [3:0]    nib;
        r        = (k << 61) | (k >> 19);
        nib      = 4'(r >> 76);
        top_mask = {4'hF, 76'd0};
        r        = (r & ~top_mask) | ({76'd0, sbox_tab[nib]} << 76);
        r        = r ^ ({75'd0, 5'(rnd % 32)} << 15);
        return r;
    endfunction

    function automatic bank_t ref_bank(input logic rst_n, input logic [KS-1:0] key);
        bank_t b;
        b = '0;
        if (rst_n) begin
            b[0] = key;
            for (int i = 1; i <= NR; i++) b[i] = ref_step(b[i-1], i);
        end
        return b;
    endfunction

    // Drive one edge's inputs, queue its expected bank, return just after the edge.
    task automatic apply(input logic rst_n, input logic [KS-1:0] key);
        reset    = rst_n;
        orig_key = key;
        exp_q.push_back(ref_bank(rst_n, key));
        @(posedge clk);
        #1;
    endtask

    task automatic check_one(input string name, input logic [KS-1:0] act, input logic [KS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every edge, compare the full bank against the oldest expectation.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            bank_t e;
            e = exp_q.pop_front();
            for (int i = 0; i <= NR; i++) begin
                checks++;
                if (keys[i] !== e[i]) begin
                    errors++;
                    $display("FAIL sb_keys[%0d] actual=%h required=%h", i, keys[i], e[i]);
                end
            end
        end
    end

    initial begin
        logic [KS-1:0] ones;
        logic [KS-1:0] rk;
        bank_t         mb;
        ones     = '1;
        reset    = 1'b0;
        orig_key = '0;

        // reset held with all-ones key
        for (int n = 0; n < 3; n++) apply(1'b0, ones);
        check_one("reset_k0", keys[0], '0);
        check_one("reset_k32", keys[32], '0);

        // zero key, golden constants
        apply(1'b1, '0);
        check_one("zero_k0", keys[0], '0);
        check_one("zero_k1", keys[1], 80'hC0000000000000008000);
        check_one("zero_k2", keys[2], 80'h50001800000000010000);

        // back-to-back change to all-ones
        apply(1'b1, ones);
        check_one("ones_k1", keys[1], 80'h2FFFFFFFFFFFFFFF7FFF);
        check_one("ones_k0", keys[0], ones);
        apply(1'b1, '0);
        check_one("b2b_zero_k1", keys[1], 80'hC0000000000000008000);

        // wrap: last step uses counter zero
        rk = {$urandom(), $urandom(), 16'($urandom())};
        apply(1'b1, rk);
        mb = ref_bank(1'b1, rk);
        check_one("wrap_k32", keys[32], ref_step(mb[31], 0));

        // random vectors back-to-back
        for (int n = 0; n < 40; n++) begin
            rk = {$urandom(), $urandom(), 16'($urandom())};
            apply(1'b1, rk);
        end

        // mid-stream reset for one edge
        rk = {$urandom(), $urandom(), 16'($urandom())};
        apply(1'b1, rk);
        apply(1'b0, ~rk);
        check_one("mid_reset_k7", keys[7], '0);
        rk = {$urandom(), $urandom(), 16'($urandom())};
        apply(1'b1, rk);
        mb = ref_bank(1'b1, rk);
        check_one("post_reset_k32", keys[32], mb[32]);

        for (int n = 0; n < 5; n++) begin
            rk = {$urandom(), $urandom(), 16'($urandom())};
            apply(1'b1, rk);
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
